// File: rtl/multi_alarm_timekeeper.sv
// multi_alarm_timekeeper
//   Real-time clock with NUM_ALARMS independently armed alarm channels and a
//   gated buzzer tone.
//   Optional feature: define MULTI_ALARM_SNOOZE_EN so that al_ack re-arms every
//   ringing channel SNOOZE_MIN minutes after the current time.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   inc_hour/inc_min/inc_sec   single-cycle time-adjust pulses (no carry)
//   al_sel                     channel addressed by al_inc, al_toggle, readout
//   al_inc/al_toggle/al_ack    alarm step, arm/disarm, acknowledge pulses
//   hours/minutes/seconds      current time
//   sec_pulse/sec_phase        once-per-second pulse, first-half-second flag
//   al_hours_rd/al_min_rd      alarm time of channel al_sel (combinational)
//   al_on/al_active            per-channel armed / ringing flags
//   buzzer                     registered tone & sec_phase & any ringing
module multi_alarm_timekeeper #(
    parameter int CLK_HZ     = 31_500_000,
    parameter int NUM_ALARMS = 2,
    parameter int HOUR_24    = 0,
    parameter int BUZZ_HALF  = 5000,
    parameter int AL_STEP    = 10,
    parameter int SNOOZE_MIN = 5,
    localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc_hour,
    input  logic                  inc_min,
    input  logic                  inc_sec,
    input  logic [AW-1:0]         al_sel,
    input  logic                  al_inc,
    input  logic                  al_toggle,
    input  logic                  al_ack,
    output logic [4:0]            hours,
    output logic [5:0]            minutes,
    output logic [5:0]            seconds,
    output logic                  sec_pulse,
    output logic                  sec_phase,
    output logic [4:0]            al_hours_rd,
    output logic [5:0]            al_min_rd,
    output logic [NUM_ALARMS-1:0] al_on,
    output logic [NUM_ALARMS-1:0] al_active,
    output logic                  buzzer
);

    localparam logic [4:0] HMAX = (HOUR_24 != 0) ? 5'd23 : 5'd11;
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int TW = (BUZZ_HALF > 1) ? $clog2(BUZZ_HALF) : 1;
    localparam logic [PW-1:0] PS_LAST   = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] PS_HALF   = PW'(CLK_HZ / 2);
    localparam logic [TW-1:0] TONE_LAST = TW'(BUZZ_HALF - 1);
    localparam logic [5:0]    AL_WRAP   = 6'(60 - AL_STEP);

    logic [PW-1:0] ps_q, ps_n;
    logic [TW-1:0] tone_cnt_q;
    logic          tone_q;
    logic [4:0]    h_n;
    logic [5:0]    m_n, s_n;
    logic          time_chg;
    logic [4:0]    al_h_q [NUM_ALARMS];
    logic [5:0]    al_m_q [NUM_ALARMS];
    logic [4:0]    al_h_n [NUM_ALARMS];
    logic [5:0]    al_m_n [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] on_n, act_n;

    assign ps_n = (ps_q == PS_LAST) ? '0 : ps_q + 1'b1;

    // Next time: tick carry first, then manual adjusts on the carried value.
    always_comb begin
        s_n = seconds;
        m_n = minutes;
        h_n = hours;
        if (sec_pulse) begin
            if (seconds == 6'd59) begin
                s_n = '0;
                if (minutes == 6'd59) begin
                    m_n = '0;
                    h_n = (hours == HMAX) ? '0 : hours + 5'd1;
                end else begin
                    m_n = minutes + 6'd1;
                end
            end else begin
                s_n = seconds + 6'd1;
            end
        end else if (inc_sec) begin
            s_n = (seconds == 6'd59) ? '0 : seconds + 6'd1;
        end
        if (inc_min)  m_n = (m_n == 6'd59) ? '0 : m_n + 6'd1;
        if (inc_hour) h_n = (h_n == HMAX) ? '0 : h_n + 5'd1;
    end

    // Triggers only on entering a matching time, so one fire per matching second.
    assign time_chg = (h_n != hours) || (m_n != minutes) || (s_n != seconds);

`ifdef MULTI_ALARM_SNOOZE_EN
    logic [4:0] snz_h;
    logic [5:0] snz_m;
    always_comb begin
        if (minutes >= 6'(60 - SNOOZE_MIN)) begin
            snz_m = minutes - 6'(60 - SNOOZE_MIN);
            snz_h = (hours == HMAX) ? '0 : hours + 5'd1;
        end else begin
            snz_m = minutes + 6'(SNOOZE_MIN);
            snz_h = hours;
        end
    end
`endif

    // Per-channel priority: step, arm toggle, ack, disarm clear, trigger last.
    always_comb begin
        on_n        = al_on;
        act_n       = al_active;
        al_hours_rd = '0;
        al_min_rd   = '0;
        for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
            al_h_n[i] = al_h_q[i];
            al_m_n[i] = al_m_q[i];
            if (al_sel == AW'(i)) begin
                al_hours_rd = al_h_q[i];
                al_min_rd   = al_m_q[i];
                if (al_inc) begin
                    if (al_m_q[i] >= AL_WRAP) begin
                        al_m_n[i] = al_m_q[i] - AL_WRAP;
                        al_h_n[i] = (al_h_q[i] == HMAX) ? '0 : al_h_q[i] + 5'd1;
                    end else begin
                        al_m_n[i] = al_m_q[i] + 6'(AL_STEP);
                    end
                end
                if (al_toggle) on_n[i] = ~al_on[i];
            end
            if (al_ack) begin
                act_n[i] = 1'b0;
`ifdef MULTI_ALARM_SNOOZE_EN
                if (al_active[i]) begin
                    al_h_n[i] = snz_h;
                    al_m_n[i] = snz_m;
                end
`endif
            end
            if (!on_n[i]) act_n[i] = 1'b0;
            if (on_n[i] && time_chg && (s_n == '0) &&
                (h_n == al_h_q[i]) && (m_n == al_m_q[i]))
                act_n[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ps_q       <= '0;
            sec_pulse  <= 1'b0;
            sec_phase  <= 1'b0;
            tone_cnt_q <= '0;
            tone_q     <= 1'b0;
            hours      <= '0;
            minutes    <= '0;
            seconds    <= '0;
            al_on      <= '0;
            al_active  <= '0;
            buzzer     <= 1'b0;
            for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
                al_h_q[i] <= '0;
                al_m_q[i] <= '0;
            end
        end else begin
            ps_q       <= ps_n;
            // Registered look-ahead keeps both flags aligned with ps_q.
            sec_pulse  <= (ps_n == PS_LAST);
            sec_phase  <= (ps_n < PS_HALF);
            tone_cnt_q <= (tone_cnt_q == TONE_LAST) ? '0 : tone_cnt_q + 1'b1;
            if (tone_cnt_q == TONE_LAST) tone_q <= ~tone_q;
            hours      <= h_n;
            minutes    <= m_n;
            seconds    <= s_n;
            al_on      <= on_n;
            al_active  <= act_n;
            buzzer     <= tone_q & sec_phase & (|al_active);
            for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
                al_h_q[i] <= al_h_n[i];
                al_m_q[i] <= al_m_n[i];
            end
        end
    end

endmodule

// File: tb/tb_multi_alarm_timekeeper.sv
// tb_multi_alarm_timekeeper
//   Self-checking bench: directed alarm/rollover scenarios plus random pulses,
//   compared every cycle against an arithmetic reference model.
//   Three channels are used so that al_sel=3 is an addressable out-of-range value.
module tb_multi_alarm_timekeeper;

    localparam int CLK_HZ = 10;
    localparam int N      = 3;
    localparam int H24    = 0;
    localparam int BH     = 2;
    localparam int STEP   = 10;
    localparam int SNZ    = 5;
    localparam int AW     = 2;
    localparam int HRS    = (H24 != 0) ? 24 : 12;

    logic clk = 1'b0;
    logic reset = 1'b0, inc_hour = 1'b0, inc_min = 1'b0, inc_sec = 1'b0;
    logic [AW-1:0] al_sel = '0;
    logic al_inc = 1'b0, al_toggle = 1'b0, al_ack = 1'b0;
    logic [4:0] hours, al_hours_rd;
    logic [5:0] minutes, seconds, al_min_rd;
    logic sec_pulse, sec_phase, buzzer;
    logic [N-1:0] al_on, al_active;

    multi_alarm_timekeeper #(
        .CLK_HZ(CLK_HZ), .NUM_ALARMS(N), .HOUR_24(H24),
        .BUZZ_HALF(BH), .AL_STEP(STEP), .SNOOZE_MIN(SNZ)
    ) dut (
        .clk(clk), .reset(reset), .inc_hour(inc_hour), .inc_min(inc_min),
        .inc_sec(inc_sec), .al_sel(al_sel), .al_inc(al_inc),
        .al_toggle(al_toggle), .al_ack(al_ack), .hours(hours),
        .minutes(minutes), .seconds(seconds), .sec_pulse(sec_pulse),
        .sec_phase(sec_phase), .al_hours_rd(al_hours_rd), .al_min_rd(al_min_rd),
        .al_on(al_on), .al_active(al_active), .buzzer(buzzer)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: k = cycles since reset release, time fields, alarm arrays.
    int mk, mh, mm, ms, mbuz;
    int mah [N], mam [N], mon [N], mact [N];

    function automatic int pulse_at(input int k);
        return (k % CLK_HZ == CLK_HZ - 1) ? 1 : 0;
    endfunction
    function automatic int phase_at(input int k);
        return (k > 0 && (k % CLK_HZ) < CLK_HZ / 2) ? 1 : 0;
    endfunction
    function automatic int tone_at(input int k);
        return (k / BH) % 2;
    endfunction

    task automatic model_update();
        int oh, om, tod, t, any_act, chg;
        if (reset) begin
            mk = 0; mh = 0; mm = 0; ms = 0; mbuz = 0;
            for (int i = 0; i < N; i++) begin
                mah[i] = 0; mam[i] = 0; mon[i] = 0; mact[i] = 0;
            end
            return;
        end
        any_act = 0;
        for (int i = 0; i < N; i++) if (mact[i] != 0) any_act = 1;
        mbuz = tone_at(mk) & phase_at(mk) & any_act;
        oh = mh; om = mm;
        tod = mh * 3600 + mm * 60 + ms;
        if (pulse_at(mk) != 0) begin
            tod = (tod + 1) % (HRS * 3600);
            mh = tod / 3600; mm = (tod / 60) % 60; ms = tod % 60;
        end else if (inc_sec) begin
            ms = (ms + 1) % 60;
        end
        if (inc_min)  mm = (mm + 1) % 60;
        if (inc_hour) mh = (mh + 1) % HRS;
        chg = (mh * 3600 + mm * 60 + ms) != tod ? 1 : 0;
        if (pulse_at(mk) != 0 || inc_sec || inc_min || inc_hour)
            chg = ((mh != oh) || (mm != om) || (ms != tod % 60)) ? 1 : 0;
        for (int i = 0; i < N; i++) begin
            int oah = mah[i], oam = mam[i], was = mact[i];
            if (int'(al_sel) == i && al_inc) begin
                t = (oah * 60 + oam + STEP) % (HRS * 60);
                mah[i] = t / 60; mam[i] = t % 60;
            end
            if (int'(al_sel) == i && al_toggle) mon[i] = 1 - mon[i];
            if (al_ack) begin
                mact[i] = 0;
`ifdef MULTI_ALARM_SNOOZE_EN
                if (was != 0) begin
                    t = (oh * 60 + om + SNZ) % (HRS * 60);
                    mah[i] = t / 60; mam[i] = t % 60;
                end
`endif
            end
            if (mon[i] == 0) mact[i] = 0;
            if (mon[i] != 0 && chg != 0 && ms == 0 && mh == oah && mm == oam)
                mact[i] = 1;
            if (was < 0) mact[i] = 0;
        end
        mk++;
    endtask

    task automatic check_all();
        logic [N-1:0] eon, eact;
        int erh, erm;
        for (int i = 0; i < N; i++) begin
            eon[i] = (mon[i] != 0); eact[i] = (mact[i] != 0);
        end
        erh = 0; erm = 0;
        if (int'(al_sel) < N) begin
            erh = mah[al_sel]; erm = mam[al_sel];
        end
        chk("hours", 32'(hours), mh);
        chk("minutes", 32'(minutes), mm);
        chk("seconds", 32'(seconds), ms);
        chk("sec_pulse", 32'(sec_pulse), (mk == 0) ? 0 : pulse_at(mk));
        chk("sec_phase", 32'(sec_phase), phase_at(mk));
        chk("buzzer", 32'(buzzer), mbuz);
        chk("al_on", 32'(al_on), 32'(eon));
        chk("al_active", 32'(al_active), 32'(eact));
        chk("al_hours_rd", 32'(al_hours_rd), erh);
        chk("al_min_rd", 32'(al_min_rd), erm);
    endtask

    task automatic cycle();
        model_update();
        @(posedge clk);
        #1;
        check_all();
        {reset, inc_hour, inc_min, inc_sec, al_inc, al_toggle, al_ack} = '0;
    endtask

    task automatic wait_time(input int h, input int m, input int s, input bit on_pulse,
                             input int limit);
        int n;
        for (n = 0; n < limit; n++) begin
            if (mh == h && mm == m && ms == s && (!on_pulse || pulse_at(mk) != 0)) break;
            cycle();
        end
        if (n >= limit) chk("wait_reached", 0, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1; cycle();
        reset = 1'b1; cycle();
    endtask

    initial begin
        do_reset();
        chk("reset_hours", 32'(hours), 0);
        chk("reset_buzzer", 32'(buzzer), 0);

        // Drive to 11:59:59 and roll over.
        for (int i = 0; i < 59; i++) begin
            inc_hour = (i < HRS - 1); inc_min = 1'b1; inc_sec = 1'b1;
            cycle();
        end
        chk("set_h", 32'(hours), HRS - 1);
        chk("set_m", 32'(minutes), 59);
        chk("set_s", 32'(seconds), 59);
        wait_time(0, 0, 0, 1'b0, 40);
        chk("roll_h", 32'(hours), 0);
        chk("roll_m", 32'(minutes), 0);

        // inc_sec coinciding with the tick is ignored.
        wait_time(0, 0, 10, 1'b1, 200);
        inc_sec = 1'b1; cycle();
        chk("inc_sec_on_tick", 32'(seconds), 11);
        for (int i = 0; i < 59; i++) begin inc_min = 1'b1; cycle(); end
        chk("min_at_59", 32'(minutes), 59);
        inc_min = 1'b1; cycle();
        chk("min_wrap", 32'(minutes), 0);
        chk("min_wrap_h", 32'(hours), 0);

        // Alarm 1 at 00:20, ack on the trigger cycle then one cycle later.
        do_reset();
        al_sel = 2'd1;
        al_inc = 1'b1; cycle();
        al_inc = 1'b1; cycle();
        al_toggle = 1'b1; cycle();
        chk("al1_rd_m", 32'(al_min_rd), 20);
        for (int i = 0; i < 19; i++) begin inc_min = 1'b1; cycle(); end
        wait_time(0, 19, 59, 1'b1, 800);
        al_ack = 1'b1; cycle();
        chk("trig_ack_same", 32'(al_active), 32'b010);
        al_ack = 1'b1; cycle();
        chk("ack_clear", 32'(al_active), 0);
        cycle();
        chk("ack_buzz_off", 32'(buzzer), 0);

        // Ring, ack at 00:20:03, watch snooze behaviour at 00:25:00.
        do_reset();
        al_sel = 2'd1;
        al_inc = 1'b1; cycle();
        al_inc = 1'b1; cycle();
        al_toggle = 1'b1; cycle();
        for (int i = 0; i < 19; i++) begin inc_min = 1'b1; cycle(); end
        wait_time(0, 20, 0, 1'b0, 800);
        chk("trig_active", 32'(al_active), 32'b010);
        wait_time(0, 20, 3, 1'b0, 100);
        al_ack = 1'b1; cycle();
        chk("snooze_ack_clear", 32'(al_active), 0);
        wait_time(0, 25, 0, 1'b0, 4000);
`ifdef MULTI_ALARM_SNOOZE_EN
        chk("snooze_rd", 32'(al_min_rd), 25);
        chk("snooze_retrig", 32'(al_active), 32'b010);
`else
        chk("snooze_rd", 32'(al_min_rd), 20);
        chk("snooze_retrig", 32'(al_active), 0);
`endif

        // Out-of-range channel: no effect, reads 0.
        al_sel = 2'd3;
        al_inc = 1'b1; al_toggle = 1'b1; cycle();
        chk("oor_rd_h", 32'(al_hours_rd), 0);
        chk("oor_rd_m", 32'(al_min_rd), 0);

        // Alarm 2 at 00:30, let it ring, reset mid-ring.
        al_sel = 2'd2;
        for (int i = 0; i < 3; i++) begin al_inc = 1'b1; cycle(); end
        al_toggle = 1'b1; cycle();
        wait_time(0, 30, 0, 1'b0, 4000);
        for (int i = 0; i < 20; i++) cycle();
        chk("ring_active", 32'(al_active[2]), 1);
        reset = 1'b1; inc_min = 1'b1; al_toggle = 1'b1; cycle();
        chk("reset_ring_buzz", 32'(buzzer), 0);
        chk("reset_ring_act", 32'(al_active), 0);
        chk("reset_ring_min", 32'(minutes), 0);

        // Random pulses.
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 499) == 0);
            inc_hour  = ($urandom_range(0, 7) == 0);
            inc_min   = ($urandom_range(0, 5) == 0);
            inc_sec   = ($urandom_range(0, 3) == 0);
            al_sel    = AW'($urandom_range(0, 3));
            al_inc    = ($urandom_range(0, 5) == 0);
            al_toggle = ($urandom_range(0, 9) == 0);
            al_ack    = ($urandom_range(0, 15) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
